midi_note_gate: RTL and testbench
=================================

// Module: midi_note_gate
// PURPOSE
//  Upstream stage of the ADSR voice. Parses a MIDI byte stream from the UART receiver.
//  Keeps a last-note-priority note stack for one channel.
//  Drives the ADSR gate (note_on), note number (voice_freq) and velocity.
//  Forces a gate-low gap on legato note changes so the ADSR's edge detector retriggers.
// PARAMETERS
//  MIDI_CHANNEL  0  accepted MIDI channel (0..15); messages on other channels are consumed and ignored
//  STACK_DEPTH   8  held-note stack entries (2..16)
//  RETRIG_GAP    4  gate-low cycles on a legato note change; must be >=3 (ADSR edge detector has 2-cycle delay)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  rx_data      in   8  received MIDI byte
//  rx_valid     in   1  one-cycle strobe, rx_data valid
//  note_on      out  1  gate to ADSR, level
//  voice_freq   out  7  MIDI note number of current top-of-stack
//  velocity     out  7  velocity of current top-of-stack entry
//  stack_full   out  1  level, stack holds STACK_DEPTH notes
// BEHAVIOUR
//  Reset (async): note_on=0, voice_freq=0, velocity=0, stack_full=0, stack empty, parser IDLE, gate G_OFF.
//  Parser FSM (IDLE, DATA1, DATA2), advances only on rx_valid:
//   - 0xF8..0xFF (real-time): ignored, no state change.
//   - 0xF0..0xF7: clear running status -> IDLE; data bytes are discarded until the next status byte.
//   - 0x80..0xEF: store running status -> DATA1. Expected data count is 1 for 0xCn/0xDn, else 2.
//   - Data byte (bit7=0) in IDLE: discarded. After a complete message, return to DATA1 (running status).
//   - Accepted events (channel match only): 0x9n k v, v!=0 -> NOTE_ON(k,v).
//   - 0x8n k x, or 0x9n k 0 -> NOTE_OFF(k).
//   - 0xBn 0x7B x -> ALL_OFF. All other messages are consumed silently.
//  Event is registered on the edge after the completing byte (1 event/cycle max).
//  Note stack (entry = {note,vel}), updated on the edge after the event:
//   - NOTE_ON: if k present, remove it and compact. Push {k,v} on top.
//   - NOTE_ON when full (and k absent): drop the bottom (oldest) entry, then push.
//   - NOTE_OFF: remove k if present and compact. If absent: no-op.
//   - ALL_OFF: empty the stack.
//   - Exports: empty, top {note,vel}, and full.
//  Gate FSM (G_OFF, G_LOAD, G_ON, G_GAP). It compares the stack top/empty against the last-applied note.
//   - G_OFF, stack nonempty: voice_freq/velocity <= top, go G_LOAD. Next edge: note_on<=1, go G_ON.
//   - G_ON, stack empty: note_on<=0, go G_OFF. voice_freq/velocity hold their last value.
//   - G_ON, top note changed: note_on<=0, voice_freq/velocity <= top, counter<=RETRIG_GAP-1, go G_GAP.
//   - G_ON, velocity-only change (same key re-struck): same as a note change (retrigger).
//   - G_ON, top unchanged (non-top note released): no output change.
//   - G_GAP: counter decrements. At 0: note_on<=1, go G_ON. A top change during the gap reloads the
//     outputs and restarts the counter. Stack empty during the gap: go G_OFF.
//  Latency: completing byte at rx_valid edge E. voice_freq updates at E+3, note_on rises at E+4 (from G_OFF).
//  voice_freq is always stable >=1 cycle before note_on rises, because ADSR latches it in OFF/RETRIG.
//  rx_valid while a previous event is in flight: both are processed in order. There are no stalls.
// STRUCTURE
//  Package midi_pkg holds:
//   - status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PROG=4'hC, CHPRESS=4'hD);
//   - CC_ALL_NOTES_OFF=7'd123;
//   - event-type enum (EV_NONE, EV_ON, EV_OFF, EV_ALLOFF);
//   - parser and gate state encodings.
//  Sub-module midi_note_stack holds the stack storage, find/remove/compact/push logic,
//  and the top/empty/full outputs. Parser and gate FSM stay in midi_note_gate.
// TESTING
//  - Bytes 90 3C 64 (MIDI_CHANNEL=0) -> voice_freq=60, velocity=100, then note_on=1 one cycle later;
//    80 3C 00 -> note_on=0, voice_freq holds 60.
//  - Hold 60, send 90 40 50 -> note_on low exactly RETRIG_GAP cycles, voice_freq=64 before the rise;
//    release 64 -> gap, back to 60 with vel 100.
//  - Running status: 90 3C 64 3E 64 3C 00 -> stack {62}, note_on=1, voice_freq=62.
//    F8 inserted mid-message -> identical result.
//  - Wrong channel 91 3C 64 -> no output change. B0 7B 00 while holding 3 notes -> note_on=0, stack empty.
//  - Overflow: 9 distinct note-ons, DEPTH=8 -> stack_full=1, first note dropped.
//    Releasing notes 9..2 in reverse order -> note_on=0 after the last release (note 1 was never restored).
//  - Assert rst mid-G_GAP -> all outputs 0 immediately.
//    After reset, data byte 3C alone -> ignored (parser IDLE).

Source files
------------

// File: rtl/midi_note_gate_pkg.sv
// Shared MIDI constants, event types and FSM state encodings for the note gate.
package midi_pkg;

   // Status high nibbles of the channel messages the gate cares about
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHPRESS  = 4'hD;

   // Controller number of the "All Notes Off" channel-mode message
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_ON,
      EV_OFF,
      EV_ALLOFF
   } ev_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_DATA1,
      P_DATA2
   } parse_state_t;

   typedef enum logic [1:0] {
      G_OFF,
      G_LOAD,
      G_ON,
      G_GAP
   } gate_state_t;

   // Program change and channel pressure carry one data byte, all others two
   function automatic logic single_data_byte(input logic [3:0] hi);
      return (hi == PROG) || (hi == CHPRESS);
   endfunction

endpackage

// File: rtl/midi_note_gate_if.sv
// Byte stream in from the UART receiver, gate/note/velocity out to the ADSR voice.
interface midi_note_gate_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       note_on;
   logic [6:0] voice_freq;
   logic [6:0] velocity;
   logic       stack_full;

   // Byte source / voice consumer side
   modport master (
      output rx_data, rx_valid,
      input  note_on, voice_freq, velocity, stack_full
   );

   // Note gate side
   modport slave (
      input  rx_data, rx_valid,
      output note_on, voice_freq, velocity, stack_full
   );

endinterface

// File: rtl/midi_note_gate_stack.sv
// Last-note-priority stack of held notes. Entry 0 is the oldest note, entry
// count-1 is the top. Removal compacts the entries above the hole downward.
module midi_note_stack
   import midi_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  ev_t        ev_type,
   input  logic [6:0] ev_note,
   input  logic [6:0] ev_vel,
   output logic [6:0] top_note,
   output logic [6:0] top_vel,
   output logic       empty,
   output logic       full
);

   localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW = $clog2(STACK_DEPTH);

   logic [6:0]    note_q [STACK_DEPTH];
   logic [6:0]    vel_q  [STACK_DEPTH];
   logic [6:0]    note_d [STACK_DEPTH];
   logic [6:0]    vel_d  [STACK_DEPTH];
   logic [CW-1:0] count_q, count_d;

   logic          hit;
   logic [IW-1:0] hit_idx;
   logic          do_rm;
   logic [IW-1:0] rm_idx;
   logic [CW-1:0] cnt_rm;
   logic [IW-1:0] top_idx;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(STACK_DEPTH));
   assign top_idx = IW'(count_q - CW'(1));

   // Top-of-stack view; contents are don't-care while empty
   always_comb begin
      top_note = note_q[0];
      top_vel  = vel_q[0];
      if (!empty) begin
         top_note = note_q[top_idx];
         top_vel  = vel_q[top_idx];
      end
   end

   // Locate the event key among the live entries
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
         if ((CW'(i) < count_q) && (note_q[i] == ev_note)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   // Removal (by key, or of the oldest entry on overflow) followed by push/clear
   always_comb begin
      note_d  = note_q;
      vel_d   = vel_q;
      count_d = count_q;
      do_rm   = 1'b0;
      rm_idx  = hit_idx;
      cnt_rm  = count_q;

      case (ev_type)
         EV_ON: begin
            // A full stack without the key loses its bottom entry to make room
            do_rm  = hit || full;
            rm_idx = hit ? hit_idx : '0;
         end
         EV_OFF:  do_rm = hit;
         default: do_rm = 1'b0;
      endcase

      if (do_rm) begin
         for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
            if (IW'(i) >= rm_idx) begin
               note_d[i] = note_q[i + 1];
               vel_d[i]  = vel_q[i + 1];
            end
         end
         cnt_rm = count_q - CW'(1);
      end

      case (ev_type)
         EV_ON: begin
            note_d[IW'(cnt_rm)] = ev_note;
            vel_d[IW'(cnt_rm)]  = ev_vel;
            count_d             = cnt_rm + CW'(1);
         end
         EV_OFF:    count_d = cnt_rm;
         EV_ALLOFF: count_d = '0;
         default:   count_d = count_q;
      endcase
   end

   // Stack storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
         end
      end else begin
         count_q <= count_d;
         note_q  <= note_d;
         vel_q   <= vel_d;
      end
   end

endmodule

// File: rtl/midi_note_gate.sv
// MIDI byte parser, note-event decode and ADSR gate control for one voice.
// Pipeline: byte -> completed message -> channel event -> note stack -> gate.
module midi_note_gate
   import midi_pkg::*;
#(
   parameter int unsigned MIDI_CHANNEL = 0,
   parameter int unsigned STACK_DEPTH  = 8,
   parameter int unsigned RETRIG_GAP   = 4
) (
   input  logic              clk,
   input  logic              rst,
   midi_note_gate_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(RETRIG_GAP);

   // Parser state
   parse_state_t pst_q, pst_d;
   logic [7:0]   rs_q, rs_d;
   logic [6:0]   d1_q, d1_d;

   // Completed message
   logic         msg_vld_q, msg_vld_d;
   logic [7:0]   msg_st_q, msg_st_d;
   logic [6:0]   msg_d1_q, msg_d1_d;
   logic [6:0]   msg_d2_q, msg_d2_d;

   // Decoded channel event
   ev_t          ev_type_q, ev_type_d;
   logic [6:0]   ev_note_q, ev_note_d;
   logic [6:0]   ev_vel_q, ev_vel_d;

   // Stack view
   logic [6:0]   top_note, top_vel;
   logic         st_empty, st_full;

   // Gate
   gate_state_t  gst_q, gst_d;
   logic         on_q, on_d;
   logic [6:0]   freq_q, freq_d;
   logic [6:0]   vel_q, vel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic         top_diff;

   // Byte parser with running status; real-time bytes pass through untouched
   always_comb begin
      pst_d     = pst_q;
      rs_d      = rs_q;
      d1_d      = d1_q;
      msg_vld_d = 1'b0;
      msg_st_d  = msg_st_q;
      msg_d1_d  = msg_d1_q;
      msg_d2_d  = msg_d2_q;
      if (bus.rx_valid) begin
         if (bus.rx_data[7]) begin
            if (bus.rx_data >= 8'hF8) begin
               pst_d = pst_q;
            end else if (bus.rx_data >= 8'hF0) begin
               pst_d = P_IDLE;
            end else begin
               rs_d  = bus.rx_data;
               pst_d = P_DATA1;
            end
         end else begin
            case (pst_q)
               P_DATA1: begin
                  if (single_data_byte(rs_q[7:4])) begin
                     msg_vld_d = 1'b1;
                     msg_st_d  = rs_q;
                     msg_d1_d  = bus.rx_data[6:0];
                     msg_d2_d  = '0;
                  end else begin
                     d1_d  = bus.rx_data[6:0];
                     pst_d = P_DATA2;
                  end
               end
               P_DATA2: begin
                  msg_vld_d = 1'b1;
                  msg_st_d  = rs_q;
                  msg_d1_d  = d1_q;
                  msg_d2_d  = bus.rx_data[6:0];
                  pst_d     = P_DATA1;
               end
               default: pst_d = pst_q;
            endcase
         end
      end
   end

   // Turn a completed message on our channel into a stack event
   always_comb begin
      ev_type_d = EV_NONE;
      ev_note_d = msg_d1_q;
      ev_vel_d  = msg_d2_q;
      if (msg_vld_q && (msg_st_q[3:0] == 4'(MIDI_CHANNEL))) begin
         case (msg_st_q[7:4])
            NOTE_ON:  ev_type_d = (msg_d2_q != '0) ? EV_ON : EV_OFF;
            NOTE_OFF: ev_type_d = EV_OFF;
            CC:       ev_type_d = (msg_d1_q == CC_ALL_NOTES_OFF) ? EV_ALLOFF : EV_NONE;
            default:  ev_type_d = EV_NONE;
         endcase
      end
   end

   // Parser and event pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pst_q     <= P_IDLE;
         rs_q      <= '0;
         d1_q      <= '0;
         msg_vld_q <= 1'b0;
         msg_st_q  <= '0;
         msg_d1_q  <= '0;
         msg_d2_q  <= '0;
         ev_type_q <= EV_NONE;
         ev_note_q <= '0;
         ev_vel_q  <= '0;
      end else begin
         pst_q     <= pst_d;
         rs_q      <= rs_d;
         d1_q      <= d1_d;
         msg_vld_q <= msg_vld_d;
         msg_st_q  <= msg_st_d;
         msg_d1_q  <= msg_d1_d;
         msg_d2_q  <= msg_d2_d;
         ev_type_q <= ev_type_d;
         ev_note_q <= ev_note_d;
         ev_vel_q  <= ev_vel_d;
      end
   end

   midi_note_stack #(
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst      (rst),
      .ev_type  (ev_type_q),
      .ev_note  (ev_note_q),
      .ev_vel   (ev_vel_q),
      .top_note (top_note),
      .top_vel  (top_vel),
      .empty    (st_empty),
      .full     (st_full)
   );

   assign top_diff = (top_note != freq_q) || (top_vel != vel_q);

   // Gate FSM: note/velocity always settle before the gate rises, and any
   // change of the sounding entry forces a low gap so the ADSR retriggers
   always_comb begin
      gst_d  = gst_q;
      on_d   = on_q;
      freq_d = freq_q;
      vel_d  = vel_q;
      cnt_d  = cnt_q;
      case (gst_q)
         G_OFF: begin
            if (!st_empty) begin
               freq_d = top_note;
               vel_d  = top_vel;
               gst_d  = G_LOAD;
            end
         end
         G_LOAD: begin
            on_d  = 1'b1;
            gst_d = G_ON;
         end
         G_ON: begin
            if (st_empty) begin
               on_d  = 1'b0;
               gst_d = G_OFF;
            end else if (top_diff) begin
               on_d   = 1'b0;
               freq_d = top_note;
               vel_d  = top_vel;
               cnt_d  = CNT_W'(RETRIG_GAP - 1);
               gst_d  = G_GAP;
            end
         end
         G_GAP: begin
            if (st_empty) begin
               gst_d = G_OFF;
            end else if (top_diff) begin
               freq_d = top_note;
               vel_d  = top_vel;
               cnt_d  = CNT_W'(RETRIG_GAP - 1);
            end else if (cnt_q == '0) begin
               on_d  = 1'b1;
               gst_d = G_ON;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: gst_d = G_OFF;
      endcase
   end

   // Gate registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gst_q  <= G_OFF;
         on_q   <= 1'b0;
         freq_q <= '0;
         vel_q  <= '0;
         cnt_q  <= '0;
      end else begin
         gst_q  <= gst_d;
         on_q   <= on_d;
         freq_q <= freq_d;
         vel_q  <= vel_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.note_on    = on_q;
   assign bus.voice_freq = freq_q;
   assign bus.velocity   = vel_q;
   assign bus.stack_full = st_full;

endmodule

// File: tb/tb_midi_note_gate.sv
// Self-checking bench for midi_note_gate: directed vector table, latency and
// retrigger-gap sequences, overflow, reset mid-gap, and random byte streams
// compared against a message-level model of the note stack.
module tb_midi_note_gate;

   localparam int DEPTH = 8;
   localparam int GAP   = 4;
   localparam int CH    = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   midi_note_gate_if bus ();

   midi_note_gate #(
      .MIDI_CHANNEL (CH),
      .STACK_DEPTH  (DEPTH),
      .RETRIG_GAP   (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: byte-level parser state and a queue of held {note,vel}
   int         m_rs;
   bit         m_have;
   logic [6:0] m_d1;
   logic [13:0] mq[$];
   logic [13:0] m_last;

   typedef struct {
      int          n;
      logic [79:0] b;
      logic        on;
      logic [6:0]  freq;
      logic [6:0]  vel;
      logic        full;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_remove(input logic [6:0] k);
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i][13:7] == k) begin
            mq.delete(i);
            break;
         end
      end
   endtask

   task automatic model_event(input logic [3:0] hi, input logic [3:0] ch,
                              input logic [6:0] k, input logic [6:0] v);
      if (ch != 4'(CH)) return;
      if (hi == 4'h9 && v != 7'd0) begin
         m_remove(k);
         if (mq.size() == DEPTH) void'(mq.pop_front());
         mq.push_back({k, v});
      end else if (hi == 4'h8 || hi == 4'h9) begin
         m_remove(k);
      end else if (hi == 4'hB && k == 7'd123) begin
         mq.delete();
      end
      if (mq.size() > 0) m_last = mq[mq.size() - 1];
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] st;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_rs = -1;
         return;
      end
      if (b[7]) begin
         m_rs   = int'(b);
         m_have = 1'b0;
         return;
      end
      if (m_rs < 0) return;
      st = 8'(m_rs);
      if (!m_have) begin
         m_d1 = b[6:0];
         if (st[7:4] == 4'hC || st[7:4] == 4'hD) model_event(st[7:4], st[3:0], m_d1, 7'd0);
         else m_have = 1'b1;
      end else begin
         model_event(st[7:4], st[3:0], m_d1, b[6:0]);
         m_have = 1'b0;
      end
   endtask

   task automatic model_check(input string name);
      chk({name, ".on"},   32'(bus.note_on),    32'(mq.size() > 0));
      chk({name, ".freq"}, 32'(bus.voice_freq), 32'(m_last[13:7]));
      chk({name, ".vel"},  32'(bus.velocity),   32'(m_last[6:0]));
      chk({name, ".full"}, 32'(bus.stack_full), 32'(mq.size() == DEPTH));
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      model_byte(b);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      m_rs   = -1;
      m_have = 1'b0;
      mq.delete();
      m_last = '0;
   endtask

   task automatic add_vec(input int n, input logic [79:0] b, input logic on,
                          input logic [6:0] f, input logic [6:0] v, input logic full);
      vec_t t;
      t.n = n; t.b = b; t.on = on; t.freq = f; t.vel = v; t.full = full;
      vecs.push_back(t);
   endtask

   // Wait for the gate to drop and rise again; check gap length and that the
   // new note was present before the rising edge
   task automatic measure_gap(input string name, input logic [6:0] exp_f, input logic [6:0] exp_v);
      int         low  = 0;
      bit         fell = 1'b0;
      bit         done = 1'b0;
      logic [6:0] prev_f;
      prev_f = bus.voice_freq;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (!bus.note_on) begin
            fell = 1'b1;
            low++;
         end else if (fell) begin
            done = 1'b1;
            chk({name, ".pre_rise_freq"}, 32'(prev_f), 32'(exp_f));
         end
         prev_f = bus.voice_freq;
      end
      chk({name, ".rose"}, 32'(done), 32'd1);
      chk({name, ".low_cycles"}, 32'(low), 32'(GAP));
      chk({name, ".freq"}, 32'(bus.voice_freq), 32'(exp_f));
      chk({name, ".vel"},  32'(bus.velocity),   32'(exp_v));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [79:0] tmp;
      logic [7:0]  rb;
      int          r;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // ---- reset state ----
      do_reset();
      chk("reset.on",   32'(bus.note_on),    32'd0);
      chk("reset.freq", 32'(bus.voice_freq), 32'd0);
      chk("reset.vel",  32'(bus.velocity),   32'd0);
      chk("reset.full", 32'(bus.stack_full), 32'd0);

      // ---- directed vector table (each row from reset, checked after settling) ----
      add_vec(3,  80'h903C64,               1'b1, 7'd60, 7'd100, 1'b0);
      add_vec(6,  80'h903C64803C00,         1'b0, 7'd60, 7'd100, 1'b0);
      add_vec(7,  80'h903C643E643C00,       1'b1, 7'd62, 7'd100, 1'b0);
      add_vec(9,  80'h903CF8643E64F83C00,   1'b1, 7'd62, 7'd100, 1'b0);
      add_vec(3,  80'h913C64,               1'b0, 7'd0,  7'd0,   1'b0);
      add_vec(6,  80'h903C64904050,         1'b1, 7'd64, 7'd80,  1'b0);
      add_vec(9,  80'h903C64904050804000,   1'b1, 7'd60, 7'd100, 1'b0);
      add_vec(10, 80'h903C643E654066B07B00, 1'b0, 7'd64, 7'd102, 1'b0);
      add_vec(1,  80'h3C,                   1'b0, 7'd0,  7'd0,   1'b0);
      add_vec(5,  80'hC005903C64,           1'b1, 7'd60, 7'd100, 1'b0);
      add_vec(3,  80'hF03C64,               1'b0, 7'd0,  7'd0,   1'b0);
      add_vec(6,  80'h903C64F73E64,         1'b1, 7'd60, 7'd100, 1'b0);
      add_vec(6,  80'hB07B00903C00,         1'b0, 7'd0,  7'd0,   1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         do_reset();
         tmp = vecs[i].b;
         for (int j = 0; j < vecs[i].n; j++) send_byte(tmp[8*(vecs[i].n-1-j) +: 8]);
         settle(16);
         chk($sformatf("vec%0d.on", i),   32'(bus.note_on),    32'(vecs[i].on));
         chk($sformatf("vec%0d.freq", i), 32'(bus.voice_freq), 32'(vecs[i].freq));
         chk($sformatf("vec%0d.vel", i),  32'(bus.velocity),   32'(vecs[i].vel));
         chk($sformatf("vec%0d.full", i), 32'(bus.stack_full), 32'(vecs[i].full));
      end

      // ---- latency: completing byte sampled at edge E ----
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      @(negedge clk);
      bus.rx_data  = 8'h64;
      bus.rx_valid = 1'b1;
      @(posedge clk);                       // edge E
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (2) @(posedge clk);            // E+2
      @(negedge clk);
      chk("lat.freq_e2", 32'(bus.voice_freq), 32'd0);
      @(posedge clk);                       // E+3
      @(negedge clk);
      chk("lat.freq_e3", 32'(bus.voice_freq), 32'd60);
      chk("lat.vel_e3",  32'(bus.velocity),   32'd100);
      chk("lat.on_e3",   32'(bus.note_on),    32'd0);
      @(posedge clk);                       // E+4
      @(negedge clk);
      chk("lat.on_e4",   32'(bus.note_on),    32'd1);

      // ---- legato retrigger gap and release back to the held note ----
      settle(4);
      send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
      measure_gap("legato", 7'd64, 7'd80);
      send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
      measure_gap("unlegato", 7'd60, 7'd100);

      // ---- reset asserted while the gate is in its gap ----
      send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rstgap.pre_on",   32'(bus.note_on),    32'd0);
      chk("rstgap.pre_freq", 32'(bus.voice_freq), 32'd64);
      rst = 1'b1;
      #1;
      chk("rstgap.on",   32'(bus.note_on),    32'd0);
      chk("rstgap.freq", 32'(bus.voice_freq), 32'd0);
      chk("rstgap.vel",  32'(bus.velocity),   32'd0);
      chk("rstgap.full", 32'(bus.stack_full), 32'd0);
      do_reset();
      send_byte(8'h3C);
      settle(16);
      chk("idle_data.on",   32'(bus.note_on),    32'd0);
      chk("idle_data.freq", 32'(bus.voice_freq), 32'd0);

      // ---- overflow: 9 notes into 8 entries, then release 9..2 ----
      do_reset();
      send_byte(8'h90);
      for (int k = 1; k <= 9; k++) begin
         send_byte(8'(k));
         send_byte(8'h40);
      end
      settle(16);
      chk("ovf.full", 32'(bus.stack_full), 32'd1);
      chk("ovf.freq", 32'(bus.voice_freq), 32'd9);
      chk("ovf.on",   32'(bus.note_on),    32'd1);
      send_byte(8'h80);
      for (int k = 9; k >= 3; k--) begin
         send_byte(8'(k));
         send_byte(8'h00);
      end
      settle(16);
      chk("ovf.rel_full", 32'(bus.stack_full), 32'd0);
      chk("ovf.rel_freq", 32'(bus.voice_freq), 32'd2);
      chk("ovf.rel_on",   32'(bus.note_on),    32'd1);
      send_byte(8'h02);
      send_byte(8'h00);
      settle(16);
      chk("ovf.last_on",   32'(bus.note_on),    32'd0);
      chk("ovf.last_freq", 32'(bus.voice_freq), 32'd2);
      model_check("ovf.model");

      // ---- random byte streams against the model ----
      do_reset();
      for (int batch = 0; batch < 40; batch++) begin
         for (int n = 0; n < 8; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
               case ($urandom_range(0, 9))
                  0, 1:    rb = 8'h90;
                  2:       rb = 8'h80;
                  3:       rb = 8'h91;
                  4:       rb = 8'hB0;
                  5:       rb = 8'hC0;
                  6:       rb = 8'hD0;
                  7:       rb = 8'hF8;
                  8:       rb = 8'hF0;
                  default: rb = 8'h81;
               endcase
            end else if (r < 18) begin
               rb = 8'h7B;
            end else if (r < 30) begin
               rb = 8'h00;
            end else if (r < 75) begin
               rb = 8'(60 + $urandom_range(0, 9));
            end else begin
               rb = 8'($urandom_range(1, 127));
            end
            send_byte(rb);
         end
         settle(16);
         model_check($sformatf("rand%0d", batch));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
